// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared definitions for the two-requester Avalon memory bus arbiter:
// FSM state encoding, requester identifiers and the default abort timeout.
package mem_bus_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Requester identifiers (also the round-robin pointer encoding)
  localparam logic REQ_IF = 1'b0;  // instruction fetch
  localparam logic REQ_D  = 1'b1;  // data

  // Default number of waitrequest-high cycles before a transaction aborts
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage : mem_bus_pkg

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter2
// Combinational two-way round-robin grant with a registered "last granted"
// pointer. When both requests are high the requester not granted last wins;
// a single request always wins. The pointer resets to REQ_D so that fetch
// is favoured on the first contended grant after reset.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   i_req[1:0]    : bit 0 = fetch request, bit 1 = data request
//   i_update      : load the pointer with i_update_id at the next edge
//   i_update_id   : requester that was just served
//   o_valid       : at least one request is present
//   o_gnt_id      : winning requester (valid when o_valid)
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_update_id,
  output logic       o_valid,
  output logic       o_gnt_id
);

  logic r_last_id;

  // Round-robin pointer: remembers the most recently served requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_id <= REQ_D;
    end else if (i_update) begin
      r_last_id <= i_update_id;
    end else begin
      r_last_id <= r_last_id;
    end
  end

  // Grant selection; the pointer only breaks ties
  always_comb begin
    o_valid  = 1'b0;
    o_gnt_id = REQ_IF;
    case (i_req)
      2'b01: begin
        o_valid  = 1'b1;
        o_gnt_id = REQ_IF;
      end
      2'b10: begin
        o_valid  = 1'b1;
        o_gnt_id = REQ_D;
      end
      2'b11: begin
        o_valid  = 1'b1;
        o_gnt_id = ~r_last_id;
      end
      default: begin
        o_valid  = 1'b0;
        o_gnt_id = REQ_IF;
      end
    endcase
  end

endmodule : rr_arbiter2

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Arbitrates an instruction-fetch requester (read-only) and a data requester
// onto a single Avalon-MM master port. IDLE picks a winner and loads the bus
// registers, ISSUE holds the command until waitrequest falls or a timeout
// expires, RESP pulses the requester's ack and advances the round-robin.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   if_req, if_address                : fetch request / byte address
//   d_req, d_address, d_write,
//   d_writedata, d_byteenable         : data request and write payload
//   if_ack, d_ack                     : one-cycle completion pulses
//   rdata, err                        : read result / timeout flag (with ack)
//   address, read, write, writedata,
//   byteenable                        : registered Avalon master outputs
//   waitrequest, readdata             : Avalon slave response
//   if_count, d_count                 : wrapping completed-grant counters
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_address,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        if_ack,
  output logic        d_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [15:0] if_count,
  output logic [15:0] d_count
);

  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

  state_t      r_state;
  logic        r_gnt_id;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic [31:0] r_rdata;
  logic        r_if_ack;
  logic        r_d_ack;
  logic        r_err;
  logic [15:0] r_if_count;
  logic [15:0] r_d_count;

  state_t      w_state_nx;
  logic        w_gnt_id_nx;
  logic [7:0]  w_wait_nx;
  logic [7:0]  w_wait_inc;
  logic [31:0] w_address_nx;
  logic        w_read_nx;
  logic        w_write_nx;
  logic [31:0] w_writedata_nx;
  logic [3:0]  w_byteenable_nx;
  logic [31:0] w_rdata_nx;
  logic        w_if_ack_nx;
  logic        w_d_ack_nx;
  logic        w_err_nx;
  logic [15:0] w_if_count_nx;
  logic [15:0] w_d_count_nx;
  logic        w_finish;
  logic        w_arb_valid;
  logic        w_arb_id;
  logic        w_rr_update;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .i_req       ({d_req, if_req}),
    .i_update    (w_rr_update),
    .i_update_id (r_gnt_id),
    .o_valid     (w_arb_valid),
    .o_gnt_id    (w_arb_id)
  );

  assign w_wait_inc = r_wait_cnt + 8'd1;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and next-value logic for all datapath registers
  always_comb begin
    w_state_nx      = r_state;
    w_gnt_id_nx     = r_gnt_id;
    w_wait_nx       = r_wait_cnt;
    w_address_nx    = r_address;
    w_read_nx       = r_read;
    w_write_nx      = r_write;
    w_writedata_nx  = r_writedata;
    w_byteenable_nx = r_byteenable;
    w_rdata_nx      = r_rdata;
    w_if_ack_nx     = 1'b0;
    w_d_ack_nx      = 1'b0;
    w_err_nx        = 1'b0;
    w_if_count_nx   = r_if_count;
    w_d_count_nx    = r_d_count;
    w_finish        = 1'b0;
    w_rr_update     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nx  = ST_ISSUE;
          w_gnt_id_nx = w_arb_id;
          w_wait_nx   = 8'd0;
          if (w_arb_id == REQ_D) begin
            w_address_nx    = d_address;
            w_writedata_nx  = d_writedata;
            w_byteenable_nx = d_byteenable;
            w_read_nx       = ~d_write;
            w_write_nx      = d_write;
          end else begin
            w_address_nx    = if_address;
            w_writedata_nx  = 32'd0;
            w_byteenable_nx = 4'b1111;
            w_read_nx       = 1'b1;
            w_write_nx      = 1'b0;
          end
        end else begin
          w_read_nx  = 1'b0;
          w_write_nx = 1'b0;
        end
      end

      ST_ISSUE: begin
        if (!waitrequest) begin
          w_finish = 1'b1;
          // Only reads overwrite the returned data
          if (r_read) begin
            w_rdata_nx = readdata;
          end else begin
            w_rdata_nx = r_rdata;
          end
        end else if (w_wait_inc == TIMEOUT_LIM) begin
          w_finish   = 1'b1;
          w_wait_nx  = w_wait_inc;
          w_rdata_nx = 32'hFFFF_FFFF;
          w_err_nx   = 1'b1;
        end else begin
          w_wait_nx = w_wait_inc;
        end

        // Ack and counter are registered on the way into RESP so they are
        // visible during the RESP cycle itself
        if (w_finish) begin
          w_state_nx = ST_RESP;
          w_read_nx  = 1'b0;
          w_write_nx = 1'b0;
          if (r_gnt_id == REQ_D) begin
            w_d_ack_nx   = 1'b1;
            w_d_count_nx = r_d_count + 16'd1;
          end else begin
            w_if_ack_nx   = 1'b1;
            w_if_count_nx = r_if_count + 16'd1;
          end
        end else begin
          w_state_nx = ST_ISSUE;
        end
      end

      ST_RESP: begin
        w_state_nx  = ST_IDLE;
        w_rr_update = 1'b1;
        w_read_nx   = 1'b0;
        w_write_nx  = 1'b0;
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_read_nx  = 1'b0;
        w_write_nx = 1'b0;
      end
    endcase
  end

  // Bus, response and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt_id     <= REQ_IF;
      r_wait_cnt   <= 8'd0;
      r_address    <= 32'd0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= 32'd0;
      r_byteenable <= 4'd0;
      r_rdata      <= 32'd0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
      r_if_count   <= 16'd0;
      r_d_count    <= 16'd0;
    end else begin
      r_gnt_id     <= w_gnt_id_nx;
      r_wait_cnt   <= w_wait_nx;
      r_address    <= w_address_nx;
      r_read       <= w_read_nx;
      r_write      <= w_write_nx;
      r_writedata  <= w_writedata_nx;
      r_byteenable <= w_byteenable_nx;
      r_rdata      <= w_rdata_nx;
      r_if_ack     <= w_if_ack_nx;
      r_d_ack      <= w_d_ack_nx;
      r_err        <= w_err_nx;
      r_if_count   <= w_if_count_nx;
      r_d_count    <= w_d_count_nx;
    end
  end

  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign rdata      = r_rdata;
  assign if_ack     = r_if_ack;
  assign d_ack      = r_d_ack;
  assign err        = r_err;
  assign if_count   = r_if_count;
  assign d_count    = r_d_count;

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed, self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES=4).
// Expected completions are queued when a request is driven and checked
// against the ack that the DUT eventually produces.
module tb_mem_bus_arbiter;

  typedef struct {
    logic        id;     // 0 = fetch, 1 = data
    logic [31:0] rdata;
    logic        err;
    logic [15:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_address = 32'd0;
  logic        d_req = 1'b0;
  logic [31:0] d_address = 32'd0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = 32'd0;
  logic [3:0]  d_byteenable = 4'd0;
  logic        if_ack;
  logic        d_ack;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic [15:0] if_count;
  logic [15:0] d_count;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_address   (if_address),
    .d_req        (d_req),
    .d_address    (d_address),
    .d_write      (d_write),
    .d_writedata  (d_writedata),
    .d_byteenable (d_byteenable),
    .if_ack       (if_ack),
    .d_ack        (d_ack),
    .rdata        (rdata),
    .err          (err),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .if_count     (if_count),
    .d_count      (d_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] rd, input logic e, input logic [15:0] cnt);
    exp_t x;
    x.id = id; x.rdata = rd; x.err = e; x.count = cnt;
    sb.push_back(x);
  endtask

  // Wait (bounded) for an ack on a falling edge, then score it against the queue
  task automatic expect_ack(input string tag, input int max_cycles, output int waited);
    logic got;
    exp_t x;
    got = 1'b0;
    waited = 0;
    while (!got && waited <= max_cycles) begin
      @(negedge clk);
      if (if_ack || d_ack) got = 1'b1;
      else waited++;
    end
    check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, "_sb_nonempty"}, {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check({tag, "_ack_vec"}, {30'd0, if_ack, d_ack}, x.id ? 32'd1 : 32'd2);
        check({tag, "_rdata"}, rdata, x.rdata);
        check({tag, "_err"}, {31'd0, err}, {31'd0, x.err});
        check({tag, "_count"}, {16'd0, (x.id ? d_count : if_count)}, {16'd0, x.count});
        check({tag, "_rw_idle"}, {30'd0, read, write}, 32'd0);
      end
    end
  endtask

  initial begin
    int w;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_acks_err", {29'd0, if_ack, d_ack, err}, 32'd0);
    check("rst_counts", {if_count, d_count}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // ---- fetch-only read, minimum latency ----
    @(posedge clk); #1;
    if_req = 1'b1; if_address = 32'hBFC0_0000;
    waitrequest = 1'b0; readdata = 32'h1234_5678;
    push_exp(1'b0, 32'h1234_5678, 1'b0, 16'd1);
    @(negedge clk);
    check("f_idle_read", {31'd0, read}, 32'd0);
    @(negedge clk);
    check("f_cmd_read", {31'd0, read}, 32'd1);
    check("f_cmd_write", {31'd0, write}, 32'd0);
    check("f_cmd_addr", address, 32'hBFC0_0000);
    check("f_cmd_be", {28'd0, byteenable}, 32'd15);
    expect_ack("fetch", 0, w);
    if_req = 1'b0;
    @(negedge clk);
    check("f_ack_pulse", {30'd0, if_ack, d_ack}, 32'd0);
    check("f_rdata_hold", rdata, 32'h1234_5678);

    // ---- data write with 3 wait cycles ----
    @(posedge clk); #1;
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h0000_1000;
    d_byteenable = 4'b0011; d_writedata = 32'hCAFE_BABE;
    waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
    push_exp(1'b1, 32'h1234_5678, 1'b0, 16'd1);
    @(negedge clk);
    check("w_idle_write", {31'd0, write}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w_hold_rw", {30'd0, read, write}, 32'd1);
      check("w_hold_addr", address, 32'h0000_1000);
      check("w_hold_data", writedata, 32'hCAFE_BABE);
      check("w_hold_be", {28'd0, byteenable}, 32'd3);
    end
    @(posedge clk); #1 waitrequest = 1'b0;
    @(negedge clk);
    check("w_4th_cycle_write", {30'd0, read, write}, 32'd1);
    expect_ack("dwrite", 0, w);
    d_req = 1'b0; d_write = 1'b0;

    // ---- timeout on a fetch ----
    @(posedge clk); #1;
    if_req = 1'b1; if_address = 32'h0000_2000; waitrequest = 1'b1;
    push_exp(1'b0, 32'hFFFF_FFFF, 1'b1, 16'd2);
    @(negedge clk);
    check("t_idle_read", {31'd0, read}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t_wait_read", {31'd0, read}, 32'd1);
    end
    expect_ack("timeout", 0, w);
    if_req = 1'b0;
    @(negedge clk);
    check("t_err_pulse", {31'd0, err}, 32'd0);
    waitrequest = 1'b0;

    // ---- reset while a data read is in ISSUE ----
    @(posedge clk); #1;
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h0000_3000; waitrequest = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("r_pre_read", {31'd0, read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("r_async_rw", {30'd0, read, write}, 32'd0);
    check("r_async_counts", {if_count, d_count}, 32'd0);
    check("r_async_rdata", rdata, 32'd0);
    d_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("r_no_ack", {29'd0, if_ack, d_ack, err}, 32'd0);
    end
    @(posedge clk); #1 reset = 1'b0; waitrequest = 1'b0;

    // ---- both requesters held: fetch, data, fetch, data, 3 cycles apart ----
    @(posedge clk); #1;
    if_req = 1'b1; if_address = 32'h0000_4000;
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h0000_5000;
    readdata = 32'h0BAD_F00D;
    push_exp(1'b0, 32'h0BAD_F00D, 1'b0, 16'd1);
    push_exp(1'b1, 32'h0BAD_F00D, 1'b0, 16'd1);
    push_exp(1'b0, 32'h0BAD_F00D, 1'b0, 16'd2);
    push_exp(1'b1, 32'h0BAD_F00D, 1'b0, 16'd2);
    for (int i = 0; i < 4; i++) begin
      expect_ack("rr", 6, w);
      check("rr_spacing", w, 32'd2);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("rr_quiet_ack", {30'd0, if_ack, d_ack}, 32'd0);
    @(negedge clk);
    check("rr_quiet_rw", {30'd0, read, write}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_bus_arbiter

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255; number of waitrequest-high cycles before a transaction is aborted.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: if_req, d_req  input  1 each  requester 0 (instruction fetch) and requester 1 (data) transaction request; held until ack.
REQ-005 Port: if_address, d_address  input  32 each  byte address.
REQ-006 Port: d_write  input  1  data requester: 1 = write, 0 = read. The fetch requester is read-only.
REQ-007 Port: d_writedata  input  32; d_byteenable  input  4; fetch byteenable is fixed at 4'b1111.
REQ-008 Port: if_ack, d_ack  output  1 each  one-cycle completion pulse.
REQ-009 Port: rdata  output  32  registered read result; valid in the ack cycle; holds its value otherwise.
REQ-010 Port: err  output  1  pulses with ack when the transaction timed out.
REQ-011 Port: address, read, write, writedata, byteenable  output  32/1/1/32/4  Avalon master side, all registered.
REQ-012 Port: waitrequest  input  1; readdata  input  32  Avalon slave response.
REQ-013 Port: if_count, d_count  output  16 each  wrapping count of completed grants per requester.

Function
REQ-014 The FSM shall have three states: IDLE, ISSUE, RESP.
REQ-015 IDLE: if any req is high, select a winner, latch its address/write/writedata/byteenable into the bus registers, assert read or write, and go to ISSUE on the next edge.
REQ-016 Arbitration shall be round-robin: when both reqs are high, grant the requester not granted last; after reset, fetch wins first.
REQ-017 When only one req is high, that requester shall be granted regardless of the round-robin pointer.
REQ-018 ISSUE: read/write shall stay asserted and the bus outputs shall stay stable while waitrequest=1.
REQ-019 ISSUE with waitrequest=0: capture readdata into rdata (reads only; writes leave rdata unchanged), deassert read/write, and go to RESP.
REQ-020 RESP: pulse ack to the granted requester for exactly one cycle, increment its count (16-bit wrap 0xFFFF->0), update the round-robin pointer, and return to IDLE.
REQ-021 Minimum latency (waitrequest=0 on the first ISSUE cycle): req high in cycle N -> bus command in N+1 -> ack in N+2; back-to-back grants start no earlier than N+3.
REQ-022 An 8-bit wait counter shall clear on entry to ISSUE and increment each ISSUE cycle that has waitrequest=1.
REQ-023 When the wait counter reaches TIMEOUT_CYCLES: deassert read/write, set rdata=32'hFFFFFFFF, go to RESP, and assert err with ack; count still increments.
REQ-024 A req that drops during ISSUE shall not abort the transaction; ack is still pulsed.
REQ-025 A req still high in the ack cycle is treated as a new request in the following IDLE cycle.
REQ-026 The arbiter shall never assert read and write together; both shall be 0 in IDLE and RESP.
REQ-027 Inputs of the non-granted requester shall be ignored until it is granted.

Reset
REQ-028 reset shall force, immediately and independently of clk: state=IDLE, read=0, write=0, address=0, writedata=0, byteenable=0, rdata=0, acks=0, err=0, counts=0, wait counter=0, pointer=fetch-first.
REQ-029 Reset during ISSUE shall drop the in-flight command with no ack; the next grant after reset release follows REQ-016.

Structure
REQ-030 The state enum (IDLE/ISSUE/RESP), requester ID constants, and the TIMEOUT_CYCLES default shall live in a shared package, mem_bus_pkg.
REQ-031 One sub-module shall be used: rr_arbiter2, a combinational two-way round-robin grant with a registered pointer. The FSM and bus registers shall stay in mem_bus_arbiter.

Verification
REQ-032 Fetch only: if_req=1, if_address=0xBFC00000, waitrequest=0, readdata=0x12345678 -> read=1 with address=0xBFC00000 one cycle later; if_ack and rdata=0x12345678 the cycle after; if_count=1.
REQ-033 Both reqs held continuously after reset -> grant order fetch, data, fetch, data; grants start 3 cycles apart.
REQ-034 Data write: d_write=1, d_byteenable=4'b0011, d_writedata=0xCAFEBABE, waitrequest high for 3 cycles -> write held 4 cycles with stable outputs; d_ack one cycle after waitrequest falls; rdata unchanged.
REQ-035 waitrequest stuck high with TIMEOUT_CYCLES=4 -> read deasserts after 4 wait cycles; ack and err pulse together; rdata=0xFFFFFFFF.
REQ-036 Assert reset mid-ISSUE -> read/write drop to 0 in the same cycle with no ack; counts=0; after release, fetch is granted first.
